// File: rtl/mtr_pkg.sv
// mtr_pkg: shared constants, types and helpers for the motor PWM driver.
//   PWM_W        - width of speed commands, duty values and the period counter
//   ZERO_DUTY    - duty for zero speed (50 %)
//   CNT_MAX      - last count of the 2048-cycle PWM period
//   DEAD_CYC_DEF - default dead-time length in clk cycles
//   nonovr_state_t - states of the per-channel non-overlap FSM
package mtr_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] ZERO_DUTY = 11'h400;
    localparam logic [PWM_W-1:0] CNT_MAX   = 11'h7FF;
    localparam int DEAD_CYC_DEF = 32;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } nonovr_state_t;

    // Signed speed -> offset-binary duty (spd + 1024). The full signed range
    // maps exactly onto 0..2047, so no saturation is required.
    function automatic logic [PWM_W-1:0] spd_to_duty(input logic [PWM_W-1:0] spd);
        return {~spd[PWM_W-1], spd[PWM_W-2:0]};
    endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// mtr_drv_if: speed-command inputs and H-bridge drive outputs of mtr_drv.
//   lft_spd/rght_spd       - signed wheel speed commands (11 bit)
//   lft_pwm1/rght_pwm1     - forward (high-side) drives
//   lft_pwm2/rght_pwm2     - reverse (low-side) drives
//   period_strt            - one-cycle pulse at the start of each PWM period
//   modport master: the command source / pin observer
//   modport slave : the driver block itself
interface mtr_drv_if;
    import mtr_pkg::*;

    logic [PWM_W-1:0] lft_spd;
    logic [PWM_W-1:0] rght_spd;
    logic             lft_pwm1;
    logic             lft_pwm2;
    logic             rght_pwm1;
    logic             rght_pwm2;
    logic             period_strt;

    modport master (
        output lft_spd, rght_spd,
        input  lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, period_strt
    );

    modport slave (
        input  lft_spd, rght_spd,
        output lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, period_strt
    );

endinterface

// File: rtl/mtr_drv_chk.sv
// mtr_drv_chk: safety checker for one complementary output pair.
//   clk  - system clock
//   pwm1 - forward drive of the pair
//   pwm2 - reverse drive of the pair
// Both switches of a half-bridge leg must never be on together.
module mtr_drv_chk (
    input logic clk,
    input logic pwm1,
    input logic pwm2
);

    a_no_shoot_through: assert property (@(posedge clk) !(pwm1 && pwm2))
        else $error("shoot-through: pwm1 and pwm2 both high");

endmodule

// File: rtl/pwm_nonovr.sv
// pwm_nonovr: one PWM channel with a double-buffered duty register and a
// non-overlap (dead-time) state machine driving a complementary output pair.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   cnt  - shared period counter (0..2047)
//   spd  - signed speed command
//   pwm1 - forward drive (registered)
//   pwm2 - reverse drive (registered)
module pwm_nonovr
    import mtr_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] spd,
    output logic             pwm1,
    output logic             pwm2
);

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

    logic [PWM_W-1:0] duty_q_r;
    logic             raw_r;
    logic             raw_d_r;
    nonovr_state_t    state_r;
    nonovr_state_t    state_s;
    logic [7:0]       dcnt_r;
    logic [7:0]       dcnt_s;
    logic             pwm1_r;
    logic             pwm1_s;
    logic             pwm2_r;
    logic             pwm2_s;
    logic             edge_s;

    // Duty buffer and raw PWM: duty only changes on the wrap so a period is
    // never cut short; raw is registered and so trails cnt by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q_r <= ZERO_DUTY;
            raw_r    <= 1'b0;
            raw_d_r  <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                duty_q_r <= spd_to_duty(spd);
            end else begin
                duty_q_r <= duty_q_r;
            end
            raw_r   <= (cnt < duty_q_r);
            raw_d_r <= raw_r;
        end
    end

    // Non-overlap FSM state, dead counter and registered output pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DEAD;
            dcnt_r  <= 8'd0;
            pwm1_r  <= 1'b0;
            pwm2_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            dcnt_r  <= dcnt_s;
            pwm1_r  <= pwm1_s;
            pwm2_r  <= pwm2_s;
        end
    end

    // Next state and next outputs. A raw edge always wins and (re)starts the
    // dead window, so pulses no longer than DEAD_CYC never reach the pins.
    // Outputs are derived from the next state so that the pair drops in the
    // same clock that the edge is seen.
    always_comb begin
        edge_s  = raw_r ^ raw_d_r;
        state_s = state_r;
        dcnt_s  = dcnt_r;
        pwm1_s  = 1'b0;
        pwm2_s  = 1'b0;
        if (edge_s) begin
            state_s = DEAD;
            dcnt_s  = 8'd0;
        end else begin
            case (state_r)
                DEAD: begin
                    if (dcnt_r == DEAD_LAST) begin
                        state_s = DRIVE;
                        dcnt_s  = 8'd0;
                    end else begin
                        state_s = DEAD;
                        dcnt_s  = dcnt_r + 8'd1;
                    end
                end
                DRIVE: begin
                    state_s = DRIVE;
                    dcnt_s  = dcnt_r;
                end
                default: begin
                    state_s = DEAD;
                    dcnt_s  = 8'd0;
                end
            endcase
        end
        if (state_s == DRIVE) begin
            pwm1_s = raw_r;
            pwm2_s = ~raw_r;
        end else begin
            pwm1_s = 1'b0;
            pwm2_s = 1'b0;
        end
    end

    assign pwm1 = pwm1_r;
    assign pwm2 = pwm2_r;

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: converts left/right signed speed commands into complementary
// H-bridge PWM pairs with dead-time insertion.
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - mtr_drv_if.slave: speed inputs, four drive outputs, period_strt
// Holds the shared 2048-cycle period counter; each wheel gets its own
// pwm_nonovr channel.
module mtr_drv
    import mtr_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    mtr_drv_if.slave    bus
);

    logic [PWM_W-1:0] cnt_r;
    logic             period_strt_r;

    // Free-running period counter; period_strt is registered so it is high
    // in exactly the cycle where cnt reads 0 after a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= {PWM_W{1'b0}};
            period_strt_r <= 1'b0;
        end else begin
            cnt_r         <= cnt_r + 11'd1;
            period_strt_r <= (cnt_r == CNT_MAX);
        end
    end

    assign bus.period_strt = period_strt_r;

    pwm_nonovr #(.DEAD_CYC(DEAD_CYC)) u_lft (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt_r),
        .spd  (bus.lft_spd),
        .pwm1 (bus.lft_pwm1),
        .pwm2 (bus.lft_pwm2)
    );

    pwm_nonovr #(.DEAD_CYC(DEAD_CYC)) u_rght (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt_r),
        .spd  (bus.rght_spd),
        .pwm1 (bus.rght_pwm1),
        .pwm2 (bus.rght_pwm2)
    );

    mtr_drv_chk u_chk_lft (
        .clk  (clk),
        .pwm1 (bus.lft_pwm1),
        .pwm2 (bus.lft_pwm2)
    );

    mtr_drv_chk u_chk_rght (
        .clk  (clk),
        .pwm1 (bus.rght_pwm1),
        .pwm2 (bus.rght_pwm2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: directed bench for mtr_drv. Two instances share clk/rst:
// dut_a with the default 32-cycle dead time, dut_b with a 4-cycle dead time.
// Per-period expectations (raw, pwm1, pwm2 and both-low cycle counts) are
// queued when the speed stimulus is applied and compared after a measured
// period; edge positions, reset state and period_strt are checked directly.
module tb_mtr_drv;
    import mtr_pkg::*;

    typedef struct {
        string tag;
        int    ch;
        int    raw;
        int    p1;
        int    p2;
        int    lo;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pos    = 0;
    int   spd_v[4];
    exp_t sb[$];

    mtr_drv_if bus_a();
    mtr_drv_if bus_b();

    mtr_drv #(.DEAD_CYC(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mtr_drv #(.DEAD_CYC(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // {raw, pwm1, pwm2} of channel c: 0 A-left, 1 A-right, 2 B-left, 3 B-right
    function automatic logic [2:0] chan(input int c);
        case (c)
            0:       return {dut_a.u_lft.raw_r,  bus_a.lft_pwm1,  bus_a.lft_pwm2};
            1:       return {dut_a.u_rght.raw_r, bus_a.rght_pwm1, bus_a.rght_pwm2};
            2:       return {dut_b.u_lft.raw_r,  bus_b.lft_pwm1,  bus_b.lft_pwm2};
            default: return {dut_b.u_rght.raw_r, bus_b.rght_pwm1, bus_b.rght_pwm2};
        endcase
    endfunction

    task automatic set_spd(input int ch, input int v);
        spd_v[ch] = v;
        case (ch)
            0:       bus_a.lft_spd  = 11'(v);
            1:       bus_a.rght_spd = 11'(v);
            2:       bus_b.lft_spd  = 11'(v);
            default: bus_b.rght_spd = 11'(v);
        endcase
    endtask

    // One clock; pos is the bench's own view of the period position.
    task automatic tick();
        logic       was_rst;
        logic       exp_ps;
        logic [2:0] v;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) begin
            pos    = 0;
            exp_ps = 1'b0;
        end else begin
            pos    = (pos + 1) % 2048;
            exp_ps = (pos == 0);
        end
        check("A_period_strt", 32'(bus_a.period_strt), 32'(exp_ps));
        check("B_period_strt", 32'(bus_b.period_strt), 32'(exp_ps));
        for (int c = 0; c < 4; c++) begin
            v = chan(c);
            check($sformatf("ch%0d_overlap", c), 32'(v[1] & v[0]), 32'd0);
        end
    endtask

    task automatic goto(input int p);
        int n;
        n = 0;
        while (pos != p && n < 4096) begin
            tick();
            n++;
        end
    endtask

    task automatic run_period();
        repeat (2048) tick();
    endtask

    // Steady-state period counts derived from duty and dead time alone.
    task automatic push(input string tag, input int ch);
        exp_t e;
        int   h, l, dc;
        dc = (ch < 2) ? 32 : 4;
        h  = spd_v[ch] + 1024;
        l  = 2048 - h;
        if (h == 0) begin
            e.p1 = 0;
            e.p2 = 2048;
        end else if (h <= dc) begin
            e.p1 = 0;
            e.p2 = 2048 - h - dc;
        end else if (l <= dc) begin
            e.p1 = 2048 - l - dc;
            e.p2 = 0;
        end else begin
            e.p1 = h - dc;
            e.p2 = l - dc;
        end
        e.raw = h;
        e.lo  = 2048 - e.p1 - e.p2;
        e.ch  = ch;
        e.tag = $sformatf("%s_ch%0d", tag, ch);
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag);
        for (int c = 0; c < 4; c++) push(tag, c);
    endtask

    // Measure one full period starting at pos 0; optionally change a speed
    // mid-period after sampling position chg_at.
    task automatic measure(input int chg_at, input int chg_ch, input int chg_val);
        int         rc[4];
        int         p1[4];
        int         p2[4];
        int         lo[4];
        logic [2:0] v;
        exp_t       e;
        for (int c = 0; c < 4; c++) begin
            rc[c] = 0; p1[c] = 0; p2[c] = 0; lo[c] = 0;
        end
        for (int i = 0; i < 2048; i++) begin
            for (int c = 0; c < 4; c++) begin
                v = chan(c);
                rc[c] += int'(v[2]);
                p1[c] += int'(v[1]);
                p2[c] += int'(v[0]);
                lo[c] += int'(v[1:0] == 2'b00);
            end
            if (i == chg_at) set_spd(chg_ch, chg_val);
            tick();
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_raw"},  rc[e.ch], e.raw);
            check({e.tag, "_pwm1"}, p1[e.ch], e.p1);
            check({e.tag, "_pwm2"}, p2[e.ch], e.p2);
            check({e.tag, "_lo"},   lo[e.ch], e.lo);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_A_cnt"},    32'(dut_a.cnt_r), 32'd0);
        check({tag, "_B_cnt"},    32'(dut_b.cnt_r), 32'd0);
        check({tag, "_A_l_duty"}, 32'(dut_a.u_lft.duty_q_r),  32'd1024);
        check({tag, "_A_r_duty"}, 32'(dut_a.u_rght.duty_q_r), 32'd1024);
        check({tag, "_B_l_duty"}, 32'(dut_b.u_lft.duty_q_r),  32'd1024);
        check({tag, "_A_l_raw"},  32'({dut_a.u_lft.raw_r, dut_a.u_lft.raw_d_r}), 32'd0);
        check({tag, "_A_l_fsm"},  32'(dut_a.u_lft.state_r), 32'(DEAD));
        check({tag, "_A_l_dcnt"}, 32'(dut_a.u_lft.dcnt_r), 32'd0);
        check({tag, "_A_pins"},   32'({bus_a.lft_pwm1, bus_a.lft_pwm2,
                                       bus_a.rght_pwm1, bus_a.rght_pwm2}), 32'd0);
        check({tag, "_B_pins"},   32'({bus_b.lft_pwm1, bus_b.lft_pwm2,
                                       bus_b.rght_pwm1, bus_b.rght_pwm2}), 32'd0);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) set_spd(c, 0);
        rst = 1'b1;
        tick();
        reset_checks("rst");
        rst = 1'b0;

        // 1: zero speed, 50 % with 32-cycle dead windows on both edges.
        run_period();
        goto(33);
        check("t1_pwm1_pre_rise", 32'(bus_a.lft_pwm1), 32'd0);
        tick();
        check("t1_pwm1_rise", 32'(bus_a.lft_pwm1), 32'd1);
        goto(1025);
        check("t1_pwm1_last", 32'(bus_a.lft_pwm1), 32'd1);
        tick();
        check("t1_pwm1_fall", 32'(bus_a.lft_pwm1), 32'd0);
        goto(1057);
        check("t1_pwm2_pre_rise", 32'(bus_a.lft_pwm2), 32'd0);
        tick();
        check("t1_pwm2_rise", 32'(bus_a.lft_pwm2), 32'd1);
        goto(0);
        for (int k = 0; k < 3; k++) begin
            push_all("t1");
            measure(-1, 0, 0);
        end

        // 2: full reverse, duty 0.
        set_spd(0, -1024);
        run_period();
        run_period();
        push_all("t2");
        measure(-1, 0, 0);

        // 3: full forward, duty 2047; the 1-cycle low pulse is swallowed.
        set_spd(0, 1023);
        run_period();
        run_period();
        push_all("t3");
        measure(-1, 0, 0);
        check("t3_pwm1_pos0", 32'(bus_a.lft_pwm1), 32'd1);
        goto(33);
        check("t3_pwm1_low_end", 32'(bus_a.lft_pwm1), 32'd0);
        tick();
        check("t3_pwm1_back", 32'(bus_a.lft_pwm1), 32'd1);
        goto(0);

        // 4: right 0 -> +512 at cnt 500; current period must be untouched.
        push_all("t4_cur");
        measure(500, 1, 512);
        push_all("t4_next");
        measure(-1, 0, 0);

        // 5: reset mid-period while lft_pwm1 is high.
        set_spd(0, 300);
        run_period();
        goto(600);
        check("t5_pre_duty", 32'(dut_a.u_lft.duty_q_r), 32'd1324);
        check("t5_pre_pwm1", 32'(bus_a.lft_pwm1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_checks("t5");
        set_spd(0, 0);
        set_spd(1, 0);
        for (int i = 1; i <= 33; i++) begin
            tick();
            check("t5_dead", 32'({bus_a.lft_pwm1, bus_a.lft_pwm2}), 32'd0);
        end
        tick();
        check("t5_pwm1_rise", 32'(bus_a.lft_pwm1), 32'd1);
        goto(1025);
        check("t5_pwm1_last", 32'(bus_a.lft_pwm1), 32'd1);
        tick();
        check("t5_pwm1_fall", 32'(bus_a.lft_pwm1), 32'd0);
        goto(0);
        push_all("t5_post");
        measure(-1, 0, 0);

        // 6: DEAD_CYC = 4 instance, pulses at and just above the dead time.
        set_spd(2, -1020);
        run_period();
        run_period();
        push_all("t6_d4");
        measure(-1, 0, 0);
        set_spd(2, -1019);
        run_period();
        run_period();
        push_all("t6_d5");
        measure(-1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
